md_unit: RTL and testbench
==========================

# md_unit

Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU. It takes the same `i_op_a`/`i_op_b` operands as the ALU and executes all eight M-extension operations with a fixed multi-cycle latency. Its registered result joins `o_alu_data` at the EX/MEM result mux. A valid/ready handshake, together with a kill input, lets the hazard unit stall the pipeline or flush an operation in flight.

## Interface
- `DATA_W`, default 32: operand/result width and iteration count. Only 32 is supported and verified.
- `i_clk`  in  1  sole clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  request. Accepted on a rising edge where `i_valid && o_ready && !i_kill`.
- `i_md_op`  in  3  RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `i_op_a`  in  32  rs1 value (multiplicand/dividend).
- `i_op_b`  in  32  rs2 value (multiplier/divisor).
- `i_kill`  in  1  flush. Aborts the current operation; no result is produced.
- `o_ready`  out  1  high only in IDLE.
- `o_valid`  out  1  one-cycle pulse; `o_md_data` is valid during that cycle.
- `o_md_data`  out  32  registered result. Holds its value until the next completion.

## Operation
- FSM states and transitions:
  - IDLE → CALC on accept.
  - CALC → DONE after 32 step edges.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `i_kill`.
- Accept edge:
  - Latch the op.
  - Latch operand magnitudes: absolute value for signed operands (a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM), raw value otherwise.
  - Latch the result-sign flag and clear the step counter.
- Inputs other than `i_kill` are ignored outside IDLE.
- Multiply (shift-add):
  - Each step adds the multiplicand into the 64-bit accumulator if the current multiplier LSB is 1, then shifts.
  - After 32 steps, negate the 64-bit product if the signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide (restoring):
  - Each step shifts the remainder left with the next dividend bit, then trial-subtracts the divisor. If the remainder is ≥ the divisor, subtract and set the quotient bit.
  - Quotient sign is sign(a)^sign(b); remainder takes the sign of a.
- Corner cases (RISC-V mandated, with the same 32-cycle latency):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- Magnitude of 0x80000000 is 0x80000000 taken as unsigned, so no overflow occurs in the datapath.
- Kill and reset behaviour:
  - `i_kill` in IDLE with `i_valid`: kill wins, nothing is accepted.
  - `i_kill` in DONE: `o_valid` has already been seen this cycle. FSM goes to IDLE and `o_md_data` is unchanged.
  - Reset mid-operation: all state is cleared immediately (asynchronous). No `o_valid` follows.

## Timing
- Reset values:
  - state IDLE, so `o_ready`=1
  - `o_valid`=0
  - `o_md_data`=0
  - step counter 0
- Accept at edge E0. Steps occur at edges E1..E32; edge E32 also applies the sign fixup/corner cases, writes `o_md_data` and enters DONE.
- `o_valid`=1 for exactly one cycle, E32–E33.
- IDLE from E33; `o_ready`=1 in the cycle after E33. The earliest next accept is E34, so throughput is one operation per 34 cycles.
- `o_ready`=0 from E0 until E33.
- `o_valid` is never asserted in the cycle after a kill or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MUL with a=7, b=0xFFFFFFFD (−3) → `o_md_data`=0xFFFFFFEB; `o_valid` is a single pulse exactly 32 edges after accept; `o_ready` is low in the interim.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Division:
  - DIV −7/2 → 0xFFFFFFFD
  - REM −7/2 → 0xFFFFFFFF
  - DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF
  - REMU 100/7 → 2
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM same operands → 0
  - All complete at the same 32-edge latency.
- Kill and reset:
  - Assert `i_kill` on the 10th CALC cycle → no `o_valid`, `o_ready`=1 next cycle, `o_md_data` keeps its prior value. A following DIVU 9/3 → 3.
  - Assert `i_reset` mid-CALC → `o_valid`=0, `o_md_data`=0, `o_ready`=1 asynchronously.
- Hold `i_valid`=1 with changing operands: exactly one accept per 34 cycles, operands changed during CALC have no effect, and a random signed/unsigned sweep of 1000 ops matches the reference model.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit for the EX stage.
// A request is accepted in IDLE, iterates one bit per clock for DATA_W
// clocks (shift-add multiply or restoring divide on operand magnitudes),
// applies the sign fixup and RISC-V corner cases on the final step, and
// pulses o_valid for one cycle with the registered result.
//
// Handshake: a request transfers on a rising edge where
// i_valid && o_ready && !i_kill; o_ready is high only in IDLE; o_valid is a
// one-cycle completion pulse; i_kill returns the unit to IDLE from any state
// without producing a result.
module md_unit #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic [2:0]        i_md_op,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   input  logic              i_kill,
   output logic              o_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_md_data
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   // funct3 encodings
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Latched operation context
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
   logic [2*DATA_W-1:0] acc_q;      // {hi, lo}: product / {remainder, quotient}
   logic                neg_q;      // negate the result after the last step
   logic                div0_q;     // divisor was zero
   logic [DATA_W-1:0]   a_raw_q;    // raw dividend, returned by REM/REMU on /0
   logic [CNT_W-1:0]    cnt_q;
   logic                valid_q;
   logic [DATA_W-1:0]   md_data_q;

   logic accept;
   logic last_step;

   // Input decode at accept
   logic              a_signed_in, b_signed_in;
   logic              a_neg_in, b_neg_in, neg_in;
   logic [DATA_W-1:0] a_mag_in, b_mag_in;

   // One iteration
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_sub;
   logic                div_ge;
   logic [2*DATA_W-1:0] div_next;
   logic [2*DATA_W-1:0] acc_step;

   // Final result
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo, rem;
   logic [DATA_W-1:0]   result;

   assign accept    = i_valid && (state_q == S_IDLE) && !i_kill;
   assign last_step = (state_q == S_CALC) && (cnt_q == LAST_STEP);

   // Decode operand signedness, magnitudes and the result sign at accept
   always_comb begin
      a_signed_in = (i_md_op == OP_MULH) || (i_md_op == OP_MULHSU) ||
                    (i_md_op == OP_DIV)  || (i_md_op == OP_REM);
      b_signed_in = (i_md_op == OP_MULH) || (i_md_op == OP_DIV) ||
                    (i_md_op == OP_REM);
      a_neg_in    = a_signed_in && i_op_a[DATA_W-1];
      b_neg_in    = b_signed_in && i_op_b[DATA_W-1];
      // 0x80000000 negates to itself and is then read as an unsigned magnitude
      a_mag_in    = a_neg_in ? (~i_op_a + 1'b1) : i_op_a;
      b_mag_in    = b_neg_in ? (~i_op_b + 1'b1) : i_op_b;
      // Remainder follows the dividend; everything else follows sign(a)^sign(b)
      if (i_md_op == OP_REM) begin
         neg_in = a_neg_in;
      end else begin
         neg_in = a_neg_in ^ b_neg_in;
      end
   end

   // One shift-add or restoring-divide iteration on the accumulator
   always_comb begin
      // Multiply: multiplier sits in acc low half and is consumed LSB first
      mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
      mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
      // Divide: dividend sits in acc low half and is consumed MSB first,
      // quotient bits enter at the bottom
      div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_sub   = div_shift - {1'b0, opnd_q};
      div_next  = {(div_ge ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                   acc_q[DATA_W-2:0], div_ge};
      acc_step  = op_q[2] ? div_next : mul_next;
   end

   // Sign fixup and divide corner cases applied to the final iteration
   always_comb begin
      prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
      quo      = acc_step[DATA_W-1:0];
      rem      = acc_step[2*DATA_W-1:DATA_W];
      case (op_q)
         OP_MUL:    result = prod_fix[DATA_W-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  result = prod_fix[2*DATA_W-1:DATA_W];
         OP_DIV:    result = div0_q ? {DATA_W{1'b1}} : (neg_q ? (~quo + 1'b1) : quo);
         OP_DIVU:   result = div0_q ? {DATA_W{1'b1}} : quo;
         OP_REM:    result = div0_q ? a_raw_q : (neg_q ? (~rem + 1'b1) : rem);
         OP_REMU:   result = div0_q ? a_raw_q : rem;
         default:   result = {DATA_W{1'b0}};
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; kill returns to IDLE from any state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_CALC;
         S_CALC: if (cnt_q == LAST_STEP) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (i_kill) begin
         state_d = S_IDLE;
      end
   end

   // FSM outputs; all are driven from registers only
   always_comb begin
      o_ready   = (state_q == S_IDLE);
      o_valid   = valid_q;
      o_md_data = md_data_q;
   end

   // Datapath: latch on accept, iterate in CALC, write result on the last step
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         op_q      <= 3'b000;
         opnd_q    <= {DATA_W{1'b0}};
         acc_q     <= {(2*DATA_W){1'b0}};
         neg_q     <= 1'b0;
         div0_q    <= 1'b0;
         a_raw_q   <= {DATA_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         valid_q   <= 1'b0;
         md_data_q <= {DATA_W{1'b0}};
      end else begin
         valid_q <= last_step && !i_kill;
         if (accept) begin
            op_q    <= i_md_op;
            opnd_q  <= i_md_op[2] ? b_mag_in : a_mag_in;
            acc_q   <= {{DATA_W{1'b0}}, (i_md_op[2] ? a_mag_in : b_mag_in)};
            neg_q   <= neg_in;
            div0_q  <= (i_op_b == {DATA_W{1'b0}});
            a_raw_q <= i_op_a;
            cnt_q   <= {CNT_W{1'b0}};
         end else if ((state_q == S_CALC) && !i_kill) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
               md_data_q <= result;
            end
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, kill/reset sequences, and a
// back-to-back randomized sweep checked against a behavioral model.
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [2:0]  i_md_op;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_kill;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_md_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  md_unit #(.DATA_W(32)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_valid   (i_valid),
    .i_md_op   (i_md_op),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .i_kill    (i_kill),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_md_data (o_md_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioral reference using native wide/signed arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as, bs;
    logic [31:0] r;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as = a;
    bs = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    r = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(as / bs));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(as % bs));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard: compare every completion against the head of the queue
  always @(negedge clk) begin
    if (!rst && (o_valid === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got o_valid=1 expected none, data %h at %0t",
                 o_md_data, $time);
      end else begin
        chk("result", o_md_data, exp_q.pop_front());
      end
    end
  end

  // driver: issue one op, push its expectation, check latency and handshake
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int first;
    int nval;
    int ready_bad;
    @(negedge clk);
    chk("ready_before", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_md_op = op;
    i_op_a  = a;
    i_op_b  = b;
    exp_q.push_back(exp);
    @(posedge clk);
    first = 0;
    nval = 0;
    ready_bad = 0;
    for (int n = 0; n <= 33; n++) begin
      if (n > 0) @(negedge clk);
      else @(negedge clk);
      if (n == 0) begin
        i_valid = 1'b0;
      end
      // operands wiggle while the unit is busy and must be ignored
      i_md_op = 3'($urandom_range(0, 7));
      i_op_a  = $urandom;
      i_op_b  = $urandom;
      if (o_valid === 1'b1) begin
        nval++;
        if (first == 0) first = n;
      end
      if (o_ready !== ((n < 33) ? 1'b0 : 1'b1)) ready_bad++;
    end
    chk("latency", 32'(first), 32'd32);
    chk("valid_pulses", 32'(nval), 32'd1);
    chk("ready_interim", 32'(ready_bad), 32'd0);
  endtask

  initial begin
    int c;
    int accepts;
    int last_acc;
    logic [31:0] ta, tb;
    logic [2:0] top;

    tbl[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF};
    tbl[7]  = '{3'b111, 32'd100,        32'd7,         32'd2};
    tbl[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{3'b111, 32'd5,          32'd0,         32'd5};
    tbl[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    tbl[12] = '{3'b110, 32'd5,          32'd0,         32'd5};

    rst = 1'b1;
    i_valid = 1'b0;
    i_md_op = 3'd0;
    i_op_a = 32'd0;
    i_op_b = 32'd0;
    i_kill = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, o_ready}, 32'd1);
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_data", o_md_data, 32'd0);

    // directed vectors
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    // kill with valid in IDLE: nothing accepted
    @(negedge clk);
    i_valid = 1'b1;
    i_kill  = 1'b1;
    i_md_op = 3'b101;
    i_op_a  = 32'd50;
    i_op_b  = 32'd5;
    @(negedge clk);
    chk("kill_idle_ready", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b0;
    i_kill  = 1'b0;
    repeat (40) @(negedge clk);

    // kill on the 10th CALC cycle
    i_valid = 1'b1;
    i_md_op = 3'b100;
    i_op_a  = 32'd1000;
    i_op_b  = 32'd7;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    chk("kill_ready", {31'b0, o_ready}, 32'd1);
    chk("kill_valid", {31'b0, o_valid}, 32'd0);
    chk("kill_data_held", o_md_data, 32'd5);
    repeat (40) @(negedge clk);
    run_op(3'b101, 32'd9, 32'd3, 32'd3);

    // asynchronous reset mid-CALC
    @(negedge clk);
    i_valid = 1'b1;
    i_md_op = 3'b000;
    i_op_a  = 32'd12345;
    i_op_b  = 32'd678;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("areset_ready", {31'b0, o_ready}, 32'd1);
    chk("areset_valid", {31'b0, o_valid}, 32'd0);
    chk("areset_data", o_md_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // back-to-back sweep with i_valid held high and operands changing each cycle
    c = 0;
    accepts = 0;
    last_acc = -1;
    i_valid = 1'b1;
    while (accepts < 1000 && c < 40000) begin
      top = 3'($urandom_range(0, 7));
      ta  = pick_opnd();
      tb  = pick_opnd();
      i_md_op = top;
      i_op_a  = ta;
      i_op_b  = tb;
      if (o_ready === 1'b1) begin
        if (last_acc >= 0) chk("spacing", 32'(c - last_acc), 32'd34);
        exp_q.push_back(ref_md(top, ta, tb));
        last_acc = c;
        accepts++;
      end
      @(negedge clk);
      c++;
    end
    i_valid = 1'b0;
    chk("sweep_accepts", 32'(accepts), 32'd1000);
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
